// File: rtl/mod_counter.sv
// Up/down modulo counter over 0..MAX_VAL with wrap or saturate, load, tc pulse and sticky ovf.
// Latency: cnt/tc/ovf are registered, so they change 1 cycle after the inputs are sampled; at_max/at_min are combinational on cnt.
// Backpressure: none; the counter updates every cycle. Define COUNTER_ASSERTS_EN to compile in the embedded assertions.
module mod_counter #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 2**WIDTH-1,
    parameter bit SAT_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             ovf,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] LP_ZERO = '0;
    localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;
    logic             r_tc;
    logic             r_ovf;

    logic [WIDTH-1:0] w_load_clamped;
    logic             w_at_max;
    logic             w_at_min;
    logic             w_boundary;
    logic [WIDTH-1:0] w_cnt_nxt;

    assign w_at_max       = (r_cnt == LP_MAX);
    assign w_at_min       = (r_cnt == LP_ZERO);
    // Load values beyond the terminal value are clamped so out-of-range states stay unreachable.
    assign w_load_clamped = (load_val > LP_MAX) ? LP_MAX : load_val;
    // A boundary event is a counting step that would leave 0..MAX_VAL; a load always masks it.
    assign w_boundary     = !load && en && (up_dn ? w_at_max : w_at_min);

    // Next count: load beats enable beats hold; boundary steps wrap or saturate.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (load) begin
            w_cnt_nxt = w_load_clamped;
        end else if (en) begin
            if (up_dn) begin
                if (w_at_max) w_cnt_nxt = SAT_MODE ? LP_MAX : LP_ZERO;
                else          w_cnt_nxt = r_cnt + LP_ONE;
            end else begin
                if (w_at_min) w_cnt_nxt = SAT_MODE ? LP_ZERO : LP_MAX;
                else          w_cnt_nxt = r_cnt - LP_ONE;
            end
        end
    end

    // Registered state: count, one-cycle tc pulse, sticky ovf where set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_tc  <= w_boundary;
            if (w_boundary)   r_ovf <= 1'b1;
            else if (clr_ovf) r_ovf <= 1'b0;
        end
    end

    assign cnt    = r_cnt;
    assign tc     = r_tc;
    assign ovf    = r_ovf;
    assign at_max = w_at_max;
    assign at_min = w_at_min;

`ifdef COUNTER_ASSERTS_EN
    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        r_cnt <= LP_MAX)
        else $display("ASSERTION cnt_range violated at %0t", $time);

    a_no_x: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({r_cnt, r_tc, r_ovf}))
        else $display("ASSERTION no_x violated at %0t", $time);

    a_step_up: assert property (@(posedge clk) disable iff (!rst_n)
        (en && !load && up_dn && !w_at_max) |=> (r_cnt == WIDTH'($past(r_cnt) + LP_ONE)))
        else $display("ASSERTION step_up violated at %0t", $time);

    a_step_dn: assert property (@(posedge clk) disable iff (!rst_n)
        (en && !load && !up_dn && !w_at_min) |=> (r_cnt == WIDTH'($past(r_cnt) - LP_ONE)))
        else $display("ASSERTION step_dn violated at %0t", $time);

    a_load: assert property (@(posedge clk) disable iff (!rst_n)
        load |=> (r_cnt == $past(w_load_clamped)))
        else $display("ASSERTION load violated at %0t", $time);

    a_tc_cause: assert property (@(posedge clk) disable iff (!rst_n)
        r_tc |-> $past(w_boundary))
        else $display("ASSERTION tc_cause violated at %0t", $time);

    a_ovf_fall: assert property (@(posedge clk) disable iff (!rst_n)
        $fell(r_ovf) |-> $past(clr_ovf))
        else $display("ASSERTION ovf_fall violated at %0t", $time);
`endif

endmodule
